// File: rtl/d_phy_multi_lane_receiver.sv
// HS-only D-PHY receiver: per-lane DDR capture and 0xB8 sync hunt at either bit phase,
// followed by per-lane deskew FIFOs that release one aligned word per byte period.
module d_phy_multi_lane_receiver #(
    parameter int LANES        = 4,
    parameter int DESKEW_DEPTH = 4,
    parameter int SKEW_WINDOW  = 8
) (
    input  logic                       clock_p,
    input  logic                       reset,
    input  logic [LANES-1:0]           data_p,
    input  logic [$clog2(LANES+1)-1:0] active_lanes,
    output logic [8*LANES-1:0]         data,
    output logic                       enable,
    output logic [LANES-1:0]           lane_synced,
    output logic                       sync_error
);
    localparam int         AW   = $clog2(LANES + 1);
    localparam int         PW   = $clog2(DESKEW_DEPTH);
    localparam int         TW   = $clog2(SKEW_WINDOW) + 1;
    localparam logic [7:0] SYNC = 8'hB8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_ERROR} state_t;

    logic [AW-1:0]    lanes_used;
    logic [LANES-1:0] active_mask;

    always_comb begin
        lanes_used = active_lanes;
        if (active_lanes == '0)
            lanes_used = AW'(1);
        else if (active_lanes > AW'(LANES))
            lanes_used = AW'(LANES);
        for (int i = 0; i < LANES; i++)
            active_mask[i] = (i < int'(lanes_used));
    end

    // Stage p0: DDR capture, one bit per edge per lane
    logic [LANES-1:0] lo_p0;
    logic [LANES-1:0] hi_p0;
    logic [8:0]       sr_p1 [LANES];

    always_ff @(negedge clock_p) begin
        lo_p0 <= data_p;
    end

    // Stage p1: two bits per posedge enter at the top, so the window is LSB-first
    always_ff @(posedge clock_p) begin
        hi_p0 <= data_p;
        for (int i = 0; i < LANES; i++)
            sr_p1[i] <= {lo_p0[i], hi_p0[i], sr_p1[i][8:2]};
    end

    logic [LANES-1:0] detect;
    logic [LANES-1:0] strobe;
    logic [LANES-1:0] odd_phase;
    logic [1:0]       cnt [LANES];
    logic [7:0]       lane_byte [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            detect[i]    = active_mask[i] && !lane_synced[i] &&
                           ((sr_p1[i][8:1] == SYNC) || (sr_p1[i][7:0] == SYNC));
            strobe[i]    = lane_synced[i] && (cnt[i] == 2'd0);
            lane_byte[i] = odd_phase[i] ? sr_p1[i][7:0] : sr_p1[i][8:1];
        end
    end

    // EVEN wins a tie, so ODD is latched only when the upper window missed
    always_ff @(posedge clock_p) begin
        if (reset) begin
            lane_synced <= '0;
            odd_phase   <= '0;
            for (int i = 0; i < LANES; i++)
                cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (detect[i]) begin
                    lane_synced[i] <= 1'b1;
                    odd_phase[i]   <= (sr_p1[i][8:1] != SYNC);
                    cnt[i]         <= 2'd3;
                end else if (lane_synced[i]) begin
                    cnt[i] <= cnt[i] - 2'd1;
                end
            end
        end
    end

    state_t           state;
    state_t           state_nx;
    logic [TW-1:0]    timer;
    logic             all_ready;
    logic             any_detect;
    logic             wr_en;
    logic             pop;
    logic             overflow;
    logic [LANES-1:0] wr;
    logic [LANES-1:0] wr_ok;
    logic [LANES-1:0] empty;
    logic [LANES-1:0] full;
    logic [PW:0]      wptr [LANES];
    logic [PW:0]      rptr [LANES];
    logic [7:0]       mem  [LANES][DESKEW_DEPTH];

    assign all_ready  = ((lane_synced | detect) & active_mask) == active_mask;
    assign any_detect = |detect;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            empty[i] = (wptr[i] == rptr[i]);
            full[i]  = (wptr[i][PW] != rptr[i][PW]) && (wptr[i][PW-1:0] == rptr[i][PW-1:0]);
        end
    end

    always_ff @(posedge clock_p) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            sync_error <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= (state == S_WAIT) ? timer + TW'(1) : '0;
            sync_error <= (state_nx == S_ERROR);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (all_ready)
                    state_nx = S_RUN;
                else if (any_detect)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (overflow)
                    state_nx = S_ERROR;
                else if (all_ready)
                    state_nx = S_RUN;
                else if (timer == TW'(SKEW_WINDOW - 1))
                    state_nx = S_ERROR;
            end
            S_RUN: begin
                if (overflow)
                    state_nx = S_ERROR;
            end
            default: state_nx = state;
        endcase
    end

    // A simultaneous pop frees a slot, so a full FIFO only overflows without one
    always_comb begin
        wr_en    = (state == S_WAIT) || (state == S_RUN);
        pop      = (state == S_RUN) && ((~empty & active_mask) == active_mask);
        wr       = strobe & active_mask & {LANES{wr_en}};
        overflow = (|(wr & full)) && !pop;
        wr_ok    = wr & (~full | {LANES{pop}});
    end

    // Stage p2: deskew FIFOs
    always_ff @(posedge clock_p) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_ok[i])
                    wptr[i] <= wptr[i] + (PW+1)'(1);
                if (pop && active_mask[i])
                    rptr[i] <= rptr[i] + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock_p) begin
        for (int i = 0; i < LANES; i++)
            if (wr_ok[i])
                mem[i][wptr[i][PW-1:0]] <= lane_byte[i];
    end

    logic [8*LANES-1:0] word;

    always_comb begin
        word = '0;
        for (int i = 0; i < LANES; i++)
            if (active_mask[i])
                word[8*i +: 8] = mem[i][rptr[i][PW-1:0]];
    end

    // Stage p3: registered aligned word
    always_ff @(posedge clock_p) begin
        if (reset) begin
            enable <= 1'b0;
            data   <= '0;
        end else begin
            enable <= pop;
            if (pop)
                data <= word;
        end
    end

endmodule

// File: tb/tb_d_phy_multi_lane_receiver.sv
// Bench for d_phy_multi_lane_receiver: bit-serial DDR lane streams, expected words
// queued at stimulus time and compared on each enable.
module tb_d_phy_multi_lane_receiver;
    localparam int         LANES        = 4;
    localparam int         DESKEW_DEPTH = 4;
    localparam int         SKEW_WINDOW  = 8;
    localparam logic [7:0] SYNC         = 8'hB8;

    logic             clock_p      = 1'b0;
    logic             reset        = 1'b1;
    logic [LANES-1:0] data_p       = '0;
    logic [2:0]       active_lanes = 3'd4;
    logic [31:0]      data;
    logic             enable;
    logic [LANES-1:0] lane_synced;
    logic             sync_error;

    d_phy_multi_lane_receiver #(
        .LANES(LANES),
        .DESKEW_DEPTH(DESKEW_DEPTH),
        .SKEW_WINDOW(SKEW_WINDOW)
    ) dut (
        .clock_p(clock_p),
        .reset(reset),
        .data_p(data_p),
        .active_lanes(active_lanes),
        .data(data),
        .enable(enable),
        .lane_synced(lane_synced),
        .sync_error(sync_error)
    );

    bit          bq [LANES][$];
    logic [31:0] exp_q [$];
    int          en_cyc [$];
    int          sync_cyc [LANES];
    int          err_cyc     = -1;
    int          cyc         = 0;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [LANES-1:0] synced_prev = '0;
    logic             err_prev    = 1'b0;

    initial forever #5 clock_p = ~clock_p;

    always @(posedge clock_p) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d words outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One new bit per lane after every clock edge, so each bit is stable at the next edge
    initial begin
        forever begin
            @(clock_p);
            #1;
            for (int i = 0; i < LANES; i++)
                data_p[i] = (bq[i].size() != 0) ? bq[i].pop_front() : 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clock_p);
            for (int i = 0; i < LANES; i++)
                if (lane_synced[i] && !synced_prev[i])
                    sync_cyc[i] = cyc;
            synced_prev = lane_synced;
            if (sync_error && !err_prev)
                err_cyc = cyc;
            err_prev = sync_error;
            if (enable) begin
                en_cyc.push_back(cyc);
                if (exp_q.size() == 0)
                    check("spurious_enable", 32'(enable), 32'd0);
                else
                    check("word", data, exp_q.pop_front());
            end
        end
    end

    task automatic push_zeros(input int ln, input int n);
        for (int i = 0; i < n; i++)
            bq[ln].push_back(1'b0);
    endtask

    task automatic push_byte(input int ln, input logic [7:0] b);
        for (int i = 0; i < 8; i++)
            bq[ln].push_back(b[i]);
    endtask

    task automatic apply_reset();
        @(negedge clock_p);
        #2;
        reset = 1'b1;
        for (int i = 0; i < LANES; i++)
            bq[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clock_p);
        @(negedge clock_p);
        #2;
        reset = 1'b0;
        en_cyc.delete();
        for (int i = 0; i < LANES; i++)
            sync_cyc[i] = -1;
        err_cyc = -1;
    endtask

    task automatic wait_words(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock_p);
            #1;
            n++;
        end
        check("words_left", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_data"}, data, 32'd0);
        check({tag, "_enable"}, 32'(enable), 32'd0);
        check({tag, "_synced"}, 32'(lane_synced), 32'd0);
        check({tag, "_error"}, 32'(sync_error), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < LANES; i++)
            sync_cyc[i] = -1;

        active_lanes = 3'd4;
        apply_reset();
        check_reset_state("rst");

        // single lane, EVEN phase: 9 lead bits put the sync LSB on a posedge sample
        active_lanes = 3'd1;
        apply_reset();
        push_zeros(0, 9);
        push_byte(0, SYNC);
        push_byte(0, 8'h12);
        push_byte(0, 8'h34);
        exp_q.push_back(32'h0000_0012);
        exp_q.push_back(32'h0000_0034);
        wait_words(200);
        check("even_synced", 32'(lane_synced), 32'h1);
        check("even_latency", en_cyc[0] - sync_cyc[0], 32'd5);
        check("even_spacing", en_cyc[1] - en_cyc[0], 32'd4);

        // same stream half a period later (ODD phase); active_lanes=0 acts as 1
        active_lanes = 3'd0;
        apply_reset();
        push_zeros(0, 10);
        push_byte(0, SYNC);
        push_byte(0, 8'h12);
        push_byte(0, 8'h34);
        exp_q.push_back(32'h0000_0012);
        exp_q.push_back(32'h0000_0034);
        wait_words(200);
        check("odd_synced", 32'(lane_synced), 32'h1);
        check("odd_spacing", en_cyc[1] - en_cyc[0], 32'd4);

        // four lanes, lane k sync delayed by 2k cycles
        active_lanes = 3'd4;
        apply_reset();
        for (int k = 0; k < LANES; k++) begin
            push_zeros(k, 9 + 4 * k);
            push_byte(k, SYNC);
            push_byte(k, 8'(8'h10 + k));
            push_byte(k, 8'(8'h20 + k));
        end
        exp_q.push_back(32'h1312_1110);
        exp_q.push_back(32'h2322_2120);
        wait_words(300);
        check("skew_synced", 32'(lane_synced), 32'hF);
        check("skew_sync_gap", sync_cyc[3] - sync_cyc[0], 32'd6);
        check("skew_latency", en_cyc[0] - sync_cyc[3], 32'd5);
        check("skew_error", 32'(sync_error), 32'd0);

        // lane 3 never syncs: error after the skew window, no output at all
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            push_zeros(k, 9);
            push_byte(k, SYNC);
            push_byte(k, 8'h55);
            push_byte(k, 8'h66);
        end
        repeat (40) @(negedge clock_p);
        #1;
        check("err_flag", 32'(sync_error), 32'd1);
        check("err_delay", err_cyc - sync_cyc[0], 32'(SKEW_WINDOW));
        check("err_enables", en_cyc.size(), 32'd0);
        check("err_synced", 32'(lane_synced), 32'h7);
        apply_reset();
        check("err_clr_error", 32'(sync_error), 32'd0);
        check("err_clr_synced", 32'(lane_synced), 32'd0);

        // two active lanes; lanes 2/3 carry random data including a sync byte
        active_lanes = 3'd2;
        apply_reset();
        push_zeros(0, 9);
        push_byte(0, SYNC);
        push_byte(0, 8'hA1);
        push_byte(0, 8'hB2);
        push_zeros(1, 9);
        push_byte(1, SYNC);
        push_byte(1, 8'hC3);
        push_byte(1, 8'hD4);
        for (int k = 2; k < LANES; k++) begin
            for (int j = 0; j < 3; j++)
                push_byte(k, 8'($urandom_range(0, 255)));
            push_byte(k, SYNC);
            for (int j = 0; j < 3; j++)
                push_byte(k, 8'($urandom_range(0, 255)));
        end
        exp_q.push_back(32'h0000_C3A1);
        exp_q.push_back(32'h0000_D4B2);
        wait_words(300);
        check("two_synced", 32'(lane_synced), 32'h3);
        check("two_error", 32'(sync_error), 32'd0);

        // reset between two words while early lanes still hold bytes, then a fresh sync
        active_lanes = 3'd4;
        apply_reset();
        for (int k = 0; k < LANES; k++) begin
            push_zeros(k, 9 + 4 * k);
            push_byte(k, SYNC);
            push_byte(k, 8'(8'h30 + k));
            push_byte(k, 8'(8'h40 + k));
        end
        exp_q.push_back(32'h3332_3130);
        wait_words(300);
        apply_reset();
        check_reset_state("mid");
        for (int k = 0; k < LANES; k++) begin
            push_zeros(k, 9);
            push_byte(k, SYNC);
            push_byte(k, 8'(8'h50 + k));
            push_byte(k, 8'(8'h60 + k));
        end
        exp_q.push_back(32'h5352_5150);
        exp_q.push_back(32'h6362_6160);
        wait_words(300);
        check("mid_latency", en_cyc[0] - sync_cyc[0], 32'd5);
        check("mid_spacing", en_cyc[1] - en_cyc[0], 32'd4);

        apply_reset();
        repeat (10) @(negedge clock_p);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
